// File: rtl/adc_spi_reader_pkg.sv
// Shared fan-controller definitions: ADC sample width, SPI reader state
// encoding and default timing for the temperature-sensor ADC link.
package fan_ctrl_pkg;

    // Width of one ADC conversion; the PID core consumes samples of this width.
    localparam int ADC_BITWIDTH    = 8;

    // Default SPI framing and timing for the serial ADC reader.
    localparam int ADC_LEAD_BITS   = 2;
    localparam int ADC_SCLK_DIV    = 4;
    localparam int ADC_CS_HIGH_MIN = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } adc_spi_state_t;

endpackage

// File: rtl/adc_spi_reader_sync_2ff.sv
// Generic single-bit two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// Periodic 3-wire SPI reader for the serial temperature ADC. Each accepted
// start runs one frame and publishes the sample with a one-cycle valid strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | cs_n high, sclk low, waiting for start_i & enable_i
// CS_SETUP | cs_n low for SCLK_DIV cycles before the first SCLK edge
// SHIFT    | LEAD_BITS+ADC_BITWIDTH SCLK periods, MISO sampled at end of low
// CS_HOLD  | cs_n high for CS_HIGH_MIN cycles; first cycle publishes sample
module adc_spi_reader #(
    parameter int ADC_BITWIDTH = fan_ctrl_pkg::ADC_BITWIDTH,
    parameter int LEAD_BITS    = fan_ctrl_pkg::ADC_LEAD_BITS,
    parameter int SCLK_DIV     = fan_ctrl_pkg::ADC_SCLK_DIV,
    parameter int CS_HIGH_MIN  = fan_ctrl_pkg::ADC_CS_HIGH_MIN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic                    adc_miso_i,
    output logic                    adc_cs_n_o,
    output logic                    adc_sclk_o,
    output logic [ADC_BITWIDTH-1:0] adc_value_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    import fan_ctrl_pkg::*;

    localparam int TOTAL_BITS = LEAD_BITS + ADC_BITWIDTH;
    localparam int HALF_MAX   = (SCLK_DIV > CS_HIGH_MIN) ? SCLK_DIV : CS_HIGH_MIN;
    localparam int CNT_W      = $clog2(HALF_MAX + 1);
    localparam int BIT_W      = $clog2(TOTAL_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(CS_HIGH_MIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(TOTAL_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(ADC_BITWIDTH);

    adc_spi_state_t          state_q, state_d;
    logic [CNT_W-1:0]        half_cnt_q, half_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sample_en;
    logic                    start_req;
    logic                    miso_sync;
    logic [ADC_BITWIDTH-1:0] shift_q;
    logic [ADC_BITWIDTH-1:0] value_q;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_miso_i),
        .q     (miso_sync)
    );

    assign start_req = start_i & enable_i;

    // State register plus registered SPI pins, strobe and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next state, half-period/bit down-counters and pin levels for next cycle.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        valid_d    = 1'b0;
        sample_en  = 1'b0;
        overrun_d  = overrun_q | (start_req & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d    = CS_SETUP;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    half_cnt_d = DIV_LOAD;
                end
            end
            CS_SETUP: begin
                if (half_cnt_q == '0) begin
                    state_d    = SHIFT;
                    half_cnt_d = DIV_LOAD;
                    bit_cnt_d  = BIT_LOAD;
                end else begin
                    half_cnt_d = half_cnt_q - CNT_ONE;
                end
            end
            SHIFT: begin
                if (half_cnt_q == '0) begin
                    half_cnt_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sample_en = 1'b1;
                        sclk_d    = 1'b1;
                    end else if (bit_cnt_q == '0) begin
                        state_d    = CS_HOLD;
                        sclk_d     = 1'b0;
                        cs_n_d     = 1'b1;
                        half_cnt_d = HOLD_LOAD;
                        valid_d    = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q - BIT_ONE;
                    end
                end else begin
                    half_cnt_d = half_cnt_q - CNT_ONE;
                end
            end
            CS_HOLD: begin
                if (half_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    half_cnt_d = half_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lead samples have the highest bit counts and are skipped; the sample
    // register is published only when a frame completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            value_q <= '0;
        end else begin
            if (sample_en && (bit_cnt_q < DATA_BITS)) begin
                shift_q <= {shift_q[ADC_BITWIDTH-2:0], miso_sync};
            end
            if (valid_d) begin
                value_q <= shift_q;
            end
        end
    end

    assign adc_cs_n_o  = cs_n_q;
    assign adc_sclk_o  = sclk_q;
    assign adc_value_o = value_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default-parameter instance plus a
// SCLK_DIV=3 / LEAD_BITS=0 instance, each driven by a small SPI ADC model.
module tb_adc_spi_reader;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // default instance
    logic       rst_n, enable, start_m, miso_m;
    logic       cs_m, sclk_m, valid_m, busy_m, ovr_m;
    logic [7:0] val_m;
    // corner instance
    logic       rst_c, enable_c, start_c, miso_c;
    logic       cs_c, sclk_c, valid_c, busy_c, ovr_c;
    logic [7:0] val_c;

    adc_spi_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .start_i     (start_m),
        .adc_miso_i  (miso_m),
        .adc_cs_n_o  (cs_m),
        .adc_sclk_o  (sclk_m),
        .adc_value_o (val_m),
        .valid_o     (valid_m),
        .busy_o      (busy_m),
        .overrun_o   (ovr_m)
    );

    adc_spi_reader #(
        .SCLK_DIV  (3),
        .LEAD_BITS (0)
    ) dut_c (
        .clk         (clk),
        .rst_n       (rst_c),
        .enable_i    (enable_c),
        .start_i     (start_c),
        .adc_miso_i  (miso_c),
        .adc_cs_n_o  (cs_c),
        .adc_sclk_o  (sclk_c),
        .adc_value_o (val_c),
        .valid_o     (valid_c),
        .busy_o      (busy_c),
        .overrun_o   (ovr_c)
    );

    // ADC models: first bit presented when CS falls, next bit on each SCLK fall.
    logic [9:0] m_bits = '0;
    logic [7:0] c_bits = '0;
    int  m_idx = 0, c_idx = 0;
    bit  m_in = 1'b0, c_in = 1'b0;

    always @(negedge cs_m or posedge cs_m or negedge sclk_m) begin
        if (cs_m !== 1'b0) begin
            m_in = 1'b0; m_idx = 0;
        end else if (!m_in) begin
            m_in = 1'b1; m_idx = 0;
        end else begin
            m_idx = m_idx + 1;
        end
    end
    assign miso_m = (m_idx < 10) ? m_bits[9 - m_idx] : 1'b0;

    always @(negedge cs_c or posedge cs_c or negedge sclk_c) begin
        if (cs_c !== 1'b0) begin
            c_in = 1'b0; c_idx = 0;
        end else if (!c_in) begin
            c_in = 1'b1; c_idx = 0;
        end else begin
            c_idx = c_idx + 1;
        end
    end
    assign miso_c = (c_idx < 8) ? c_bits[7 - c_idx] : 1'b0;

    // Bus monitor, sampled on the falling clk edge.
    logic       s_sclk[2], s_cs[2], s_valid[2];
    logic [7:0] s_val[2];
    assign s_sclk[0] = sclk_m;  assign s_sclk[1] = sclk_c;
    assign s_cs[0]   = cs_m;    assign s_cs[1]   = cs_c;
    assign s_valid[0]= valid_m; assign s_valid[1]= valid_c;
    assign s_val[0]  = val_m;   assign s_val[1]  = val_c;

    int         valid_cnt[2] = '{0, 0};
    int         valid_cyc[2] = '{0, 0};
    logic [7:0] valid_val[2];
    int         rise_cnt[2]  = '{0, 0};
    int         frame_rises[2] = '{0, 0};
    int         first_rise[2] = '{0, 0};
    int         last_edge[2] = '{0, 0};
    int         phase_bad[2] = '{0, 0};
    int         cs_fall_cnt[2] = '{0, 0};
    int         cs_rise_cyc[2] = '{0, 0};
    int         gap_min[2] = '{1000, 1000};
    logic       prev_sclk[2] = '{1'b0, 1'b0};
    logic       prev_cs[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int div;
            div = (d == 0) ? 4 : 3;
            if (s_valid[d] === 1'b1) begin
                valid_cnt[d] = valid_cnt[d] + 1;
                valid_cyc[d] = cyc;
                valid_val[d] = s_val[d];
            end
            if (s_cs[d] === 1'b0 && prev_cs[d] === 1'b1) begin
                cs_fall_cnt[d] = cs_fall_cnt[d] + 1;
                if (cs_rise_cyc[d] > 0 && (cyc - cs_rise_cyc[d]) < gap_min[d])
                    gap_min[d] = cyc - cs_rise_cyc[d];
                frame_rises[d] = 0;
                last_edge[d] = cyc;
            end
            if (s_cs[d] === 1'b1 && prev_cs[d] === 1'b0) cs_rise_cyc[d] = cyc;
            if (s_sclk[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
                rise_cnt[d] = rise_cnt[d] + 1;
                frame_rises[d] = frame_rises[d] + 1;
                if (frame_rises[d] == 1) first_rise[d] = cyc;
                else if (cyc - last_edge[d] != div) phase_bad[d] = phase_bad[d] + 1;
                last_edge[d] = cyc;
            end
            if (s_sclk[d] === 1'b0 && prev_sclk[d] === 1'b1) begin
                if (cyc - last_edge[d] != div) phase_bad[d] = phase_bad[d] + 1;
                last_edge[d] = cyc;
            end
            prev_sclk[d] = s_sclk[d];
            prev_cs[d]   = s_cs[d];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int d, output int t);
        if (d == 0) start_m = 1'b1; else start_c = 1'b1;
        t = cyc;
        @(negedge clk);
        start_m = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_idle(input int d, output int at);
        int n;
        n = 0;
        while (((d == 0) ? busy_m : busy_c) !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", (d == 0) ? busy_m : busy_c, 0);
        at = cyc;
    endtask

    task automatic wait_valid(input int d, input int base);
        int n;
        n = 0;
        while (valid_cnt[d] == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(valid_cnt[d] > base), 1);
    endtask

    typedef struct {
        logic [1:0] lead;
        logic [7:0] data;
        logic [7:0] exp_value;
        int         exp_valid_ofs;
        int         exp_idle_ofs;
        int         exp_rises;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int t, at, vc, rc, pb, cf;

        #(100 * 30000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, at, vc, rc, pb, cf;

        vecs[0] = '{lead: 2'b11, data: 8'hA5, exp_value: 8'hA5, exp_valid_ofs: 85, exp_idle_ofs: 89, exp_rises: 10};
        vecs[1] = '{lead: 2'b11, data: 8'h00, exp_value: 8'h00, exp_valid_ofs: 85, exp_idle_ofs: 89, exp_rises: 10};
        vecs[2] = '{lead: 2'b00, data: 8'hFF, exp_value: 8'hFF, exp_valid_ofs: 85, exp_idle_ofs: 89, exp_rises: 10};
        vecs[3] = '{lead: 2'b10, data: 8'h3C, exp_value: 8'h3C, exp_valid_ofs: 85, exp_idle_ofs: 89, exp_rises: 10};

        rst_n = 1'b0; rst_c = 1'b0;
        enable = 1'b1; enable_c = 1'b1;
        start_m = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_m, 1);
        chk("rst_sclk", sclk_m, 0);
        chk("rst_value", val_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_overrun", ovr_m, 0);
        chk("rst_c_cs_n", cs_c, 1);
        chk("rst_c_busy", busy_c, 0);
        rst_n = 1'b1; rst_c = 1'b1;
        @(negedge clk);

        // basic read and back-to-back frames, each started in the first idle cycle
        for (int i = 0; i < 4; i++) begin
            m_bits = {vecs[i].lead, vecs[i].data};
            wait_idle(0, at);
            vc = valid_cnt[0]; rc = rise_cnt[0]; pb = phase_bad[0];
            pulse_start(0, t);
            chk("cs_fall_t1", cs_m, 0);
            chk("busy_t1", busy_m, 1);
            wait_valid(0, vc);
            chk("valid_ofs", 32'(valid_cyc[0] - t), 32'(vecs[i].exp_valid_ofs));
            chk("valid_value", valid_val[0], vecs[i].exp_value);
            chk("first_rise_ofs", 32'(first_rise[0] - t), 9);
            wait_idle(0, at);
            chk("idle_ofs", 32'(at - t), 32'(vecs[i].exp_idle_ofs));
            chk("sclk_rises", 32'(rise_cnt[0] - rc), 32'(vecs[i].exp_rises));
            chk("valid_pulses", 32'(valid_cnt[0] - vc), 1);
            chk("phase_len", 32'(phase_bad[0] - pb), 0);
        end
        chk("b2b_overrun", ovr_m, 0);
        chk("cs_gap_ge4", 32'(gap_min[0] >= 4), 1);

        // enable low: start ignored, no overrun, value held
        enable = 1'b0;
        cf = cs_fall_cnt[0];
        pulse_start(0, t);
        repeat (5) @(negedge clk);
        chk("en_off_cs_n", cs_m, 1);
        chk("en_off_busy", busy_m, 0);
        chk("en_off_overrun", ovr_m, 0);
        chk("en_off_frames", 32'(cs_fall_cnt[0] - cf), 0);
        chk("value_hold", val_m, 8'h3C);

        // enable dropped mid-frame: frame still completes
        enable = 1'b1;
        m_bits = {2'b01, 8'h5A};
        vc = valid_cnt[0];
        pulse_start(0, t);
        repeat (29) @(negedge clk);
        enable = 1'b0;
        wait_valid(0, vc);
        chk("en_drop_valid_ofs", 32'(valid_cyc[0] - t), 85);
        chk("en_drop_value", valid_val[0], 8'h5A);
        wait_idle(0, at);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("en_drop_hold", val_m, 8'h5A);

        // reset mid-frame
        m_bits = {2'b11, 8'hC3};
        vc = valid_cnt[0];
        pulse_start(0, t);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_cs_n", cs_m, 1);
        chk("midrst_sclk", sclk_m, 0);
        chk("midrst_value", val_m, 0);
        chk("midrst_busy", busy_m, 0);
        repeat (100) @(negedge clk);
        chk("midrst_no_valid", 32'(valid_cnt[0] - vc), 0);
        m_bits = {2'b00, 8'h96};
        vc = valid_cnt[0];
        pulse_start(0, t);
        wait_valid(0, vc);
        chk("postrst_valid_ofs", 32'(valid_cyc[0] - t), 85);
        chk("postrst_value", valid_val[0], 8'h96);
        wait_idle(0, at);

        // overrun: second start at T+20
        m_bits = {2'b00, 8'h42};
        vc = valid_cnt[0]; cf = cs_fall_cnt[0];
        chk("ovr_clear_before", ovr_m, 0);
        pulse_start(0, t);
        repeat (19) @(negedge clk);
        chk("ovr_not_early", ovr_m, 0);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        chk("ovr_set_t21", ovr_m, 1);
        wait_valid(0, vc);
        chk("ovr_valid_ofs", 32'(valid_cyc[0] - t), 85);
        chk("ovr_value", valid_val[0], 8'h42);
        wait_idle(0, at);
        repeat (10) @(negedge clk);
        chk("ovr_one_valid", 32'(valid_cnt[0] - vc), 1);
        chk("ovr_one_frame", 32'(cs_fall_cnt[0] - cf), 1);
        chk("ovr_sticky", ovr_m, 1);

        // parameter corner: SCLK_DIV=3, LEAD_BITS=0
        c_bits = 8'h81;
        vc = valid_cnt[1]; rc = rise_cnt[1]; pb = phase_bad[1];
        pulse_start(1, t);
        chk("c_cs_fall_t1", cs_c, 0);
        wait_valid(1, vc);
        chk("c_valid_ofs", 32'(valid_cyc[1] - t), 52);
        chk("c_value", valid_val[1], 8'h81);
        chk("c_first_rise_ofs", 32'(first_rise[1] - t), 7);
        wait_idle(1, at);
        chk("c_idle_ofs", 32'(at - t), 56);
        chk("c_sclk_rises", 32'(rise_cnt[1] - rc), 8);
        chk("c_phase_len", 32'(phase_bad[1] - pb), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Upstream stage of the fan controller core.
- Periodically reads an external 8-bit serial ADC (temperature sensor path) over a 3-wire SPI link: CS_n, SCLK, MISO.
- Delivers each completed sample as adc_value_o with a one-cycle valid_o strobe. This replaces the manual ui_in/strobe loading of ADC_value.
- Conversions are triggered by start_i, normally tied to the PID clock-enable pulse, so a fresh sample exists every PID update.

Parameters:
- ADC_BITWIDTH, 8: data bits per conversion, MSB first.
- LEAD_BITS, 2: SCLK periods at the start of each frame whose samples are discarded (ADC sample/null bits).
- SCLK_DIV, 4: clk cycles per SCLK half-period; legal range 3..15.
- CS_HIGH_MIN, 4: clk cycles CS_n is held high after a frame before a new start is accepted.

Ports:
- clk, input, 1: system clock, 10 MHz.
- rst_n, input, 1: synchronous, active-low reset.
- enable_i, input, 1: global enable (top-level ena). When low, new starts are ignored.
- start_i, input, 1: conversion request. Single-cycle pulse, sampled every cycle.
- adc_miso_i, input, 1: serial data from the ADC. Asynchronous.
- adc_cs_n_o, output, 1: ADC chip select, active low.
- adc_sclk_o, output, 1: SPI clock, idle low.
- adc_value_o, output, ADC_BITWIDTH: last completed sample.
- valid_o, output, 1: one-cycle strobe; adc_value_o has just been updated.
- busy_o, output, 1: high while not in IDLE.
- overrun_o, output, 1: sticky flag; a start arrived while busy.

Behaviour:
- Reset values (registered outputs): adc_cs_n_o=1, adc_sclk_o=0, adc_value_o=0, valid_o=0, busy_o=0, overrun_o=0, state=IDLE, internal counters 0.
- MISO input: passes through a 2-FF synchronizer before use. SCLK_DIV>=3 guarantees data is stable at the sample point.
- States:
  - IDLE: cs_n=1, sclk=0. If start_i & enable_i, go to CS_SETUP next cycle.
  - CS_SETUP: cs_n=0, sclk=0, lasts SCLK_DIV cycles, then go to SHIFT.
  - SHIFT: LEAD_BITS+ADC_BITWIDTH SCLK periods. Each period is SCLK_DIV cycles low followed by SCLK_DIV cycles high.
    - The synchronized MISO is sampled on the last clk cycle of each low phase.
    - The first LEAD_BITS samples are discarded; the next ADC_BITWIDTH samples shift into a register MSB first.
  - CS_HOLD: entered after the last high phase. sclk=0, cs_n=1.
    - On the first cycle of CS_HOLD: adc_value_o <= shift register, valid_o=1 for exactly that cycle.
    - Lasts CS_HIGH_MIN cycles, then go to IDLE.
- Timing: start sampled at cycle T gives cs_n low at T+1 and valid_o at T+1+SCLK_DIV+2*SCLK_DIV*(LEAD_BITS+ADC_BITWIDTH). With defaults, valid_o is at T+85 and the block is back in IDLE (busy_o=0) at T+85+CS_HIGH_MIN = T+89.
- busy_o is high from T+1 until IDLE is re-entered.
- start_i in the same cycle the block returns to IDLE: not accepted. It is accepted only in a cycle where state==IDLE before the edge.
- start_i & enable_i while busy: ignored, overrun_o <= 1. overrun_o clears only on reset.
- enable_i low: start_i is ignored, no overrun. A frame already in progress completes normally, including valid_o.
- adc_value_o holds its value between frames. Only a completed frame updates it; an aborted frame never does.
- Reset mid-frame: on the reset edge cs_n=1, sclk=0, adc_value_o=0, no valid_o pulse, state=IDLE.
- Counters wrap nowhere. The half-period counter reloads at SCLK_DIV-1; the bit counter covers 0..LEAD_BITS+ADC_BITWIDTH-1.

Decomposition:
- Shared package fan_ctrl_pkg:
  - ADC_BITWIDTH constant, shared with the PID core.
  - adc_spi_state_t encoding: IDLE, CS_SETUP, SHIFT, CS_HOLD.
  - Default SCLK_DIV and CS_HIGH_MIN constants.
- One sub-module: sync_2ff, a generic single-bit two-flop synchronizer used for adc_miso_i.

Test Plan:
- Basic read: defaults; ADC model drives 2 lead bits then 0xA5 on SCLK falling edges; start at T.
  - cs_n falls at T+1; exactly 10 SCLK rising edges.
  - valid_o high only at T+85 with adc_value_o=0xA5.
  - busy_o low at T+89.
- Back-to-back frames: model returns 0x00, then 0xFF, then 0x3C; a start is issued each cycle the block is in IDLE.
  - Three valid_o pulses with values 0x00, 0xFF, 0x3C.
  - overrun_o=0; CS_n high for >=4 cycles between frames.
- Overrun: start at T and again at T+20.
  - Second start ignored; only one frame and one valid_o.
  - overrun_o=1 from T+21 and stays set.
- Enable gating: enable_i=0 with a start → cs_n stays 1, busy_o=0, overrun_o=0. enable_i dropped at T+30 mid-frame → frame completes with a valid_o pulse at T+85.
- Reset mid-frame: rst_n low at T+40 for one cycle.
  - Next cycle cs_n=1, sclk=0, adc_value_o=0, busy_o=0.
  - No valid_o pulse; a following start produces a correct frame.
- Parameter corner: SCLK_DIV=3, LEAD_BITS=0, MISO=0x81.
  - valid_o at T+1+3+48 = T+52 with adc_value_o=0x81.
  - Each SCLK phase is 3 cycles.
